// File: rtl/traffic_demand_detector.sv
// Conditions the four raw loop detectors into latched per-approach demand requests,
// cleared when the approach is served green and aged toward a starvation flag.
module traffic_demand_detector #(
  parameter int DEBOUNCE = 4,
  parameter int MAX_WAIT = 64
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       ns_det,
  input  logic       ew_det,
  input  logic       sw_ne_det,
  input  logic       wn_es_det,
  input  logic [2:0] ns_light,
  input  logic [2:0] ew_light,
  input  logic [2:0] sw_ne_light,
  input  logic [2:0] wn_es_light,
  output logic       ns_traffic,
  output logic       ew_traffic,
  output logic       sw_ne_traffic,
  output logic       wn_es_traffic,
  output logic [3:0] starved,
  output logic [2:0] pending_count
);

  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam int AW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE);
  localparam logic [CW-1:0] CNT_SET = CW'(DEBOUNCE - 1);
  localparam logic [AW-1:0] AGE_MAX = AW'(MAX_WAIT);

  logic [3:0]      det;
  logic [3:0][2:0] light;
  logic [3:0]      req;

  assign det   = {wn_es_det, sw_ne_det, ew_det, ns_det};
  assign light = {wn_es_light, sw_ne_light, ew_light, ns_light};

  for (genvar i = 0; i < 4; i++) begin : g_lane
    logic          s1_q, s1_d;
    logic          s2_q, s2_d;
    logic          prev_green_q, prev_green_d;
    logic          req_q, req_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] age_q, age_d;
    logic          green;
    logic          green_edge;

    always_comb begin
      green        = (light[i] == 3'b001);
      green_edge   = green & ~prev_green_q;
      s1_d         = det[i];
      s2_d         = s1_q;
      prev_green_d = green;
      cnt_d        = cnt_q;
      req_d        = req_q;
      age_d        = age_q;

      // A served approach cannot build up a new request while it is green.
      if (green || !s2_q) begin
        cnt_d = '0;
      end else if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CW'(1);
      end

      // The green-edge clear takes priority over a request latching on the same edge.
      if (green_edge) begin
        req_d = 1'b0;
      end else if (!green && s2_q && (cnt_q == CNT_SET)) begin
        req_d = 1'b1;
      end

      if (!req_q || green_edge) begin
        age_d = '0;
      end else if (age_q != AGE_MAX) begin
        age_d = age_q + AW'(1);
      end
    end

    always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
        s1_q         <= 1'b0;
        s2_q         <= 1'b0;
        prev_green_q <= 1'b0;
        req_q        <= 1'b0;
        cnt_q        <= '0;
        age_q        <= '0;
      end else begin
        s1_q         <= s1_d;
        s2_q         <= s2_d;
        prev_green_q <= prev_green_d;
        req_q        <= req_d;
        cnt_q        <= cnt_d;
        age_q        <= age_d;
      end
    end

    assign req[i]     = req_q;
    assign starved[i] = (age_q == AGE_MAX);
  end

  assign ns_traffic    = req[0];
  assign ew_traffic    = req[1];
  assign sw_ne_traffic = req[2];
  assign wn_es_traffic = req[3];

  assign pending_count = {2'b00, req[0]} + {2'b00, req[1]} + {2'b00, req[2]} + {2'b00, req[3]};

endmodule

// File: tb/tb_traffic_demand_detector.sv
// Directed bench for traffic_demand_detector with DEBOUNCE=4, MAX_WAIT=8:
// a vector table for the reset/serve flow plus hand sequences for the timing corners.
module tb_traffic_demand_detector;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] G = 3'b001;

  logic       CLK;
  logic       RST;
  logic       ns_det, ew_det, sw_ne_det, wn_es_det;
  logic [2:0] ns_light, ew_light, sw_ne_light, wn_es_light;
  logic       ns_traffic, ew_traffic, sw_ne_traffic, wn_es_traffic;
  logic [3:0] starved;
  logic [2:0] pending_count;

  int checks;
  int failures;

  typedef struct {
    logic        rst_n;
    logic [3:0]  det;
    logic [11:0] lights;
    int          ncyc;
    logic [3:0]  traffic;
    logic [3:0]  starv;
    logic [2:0]  pend;
    string       name;
  } vec_t;

  vec_t vecs[14];

  traffic_demand_detector #(.DEBOUNCE(4), .MAX_WAIT(8)) dut (
    .CLK           (CLK),
    .RST           (RST),
    .ns_det        (ns_det),
    .ew_det        (ew_det),
    .sw_ne_det     (sw_ne_det),
    .wn_es_det     (wn_es_det),
    .ns_light      (ns_light),
    .ew_light      (ew_light),
    .sw_ne_light   (sw_ne_light),
    .wn_es_light   (wn_es_light),
    .ns_traffic    (ns_traffic),
    .ew_traffic    (ew_traffic),
    .sw_ne_traffic (sw_ne_traffic),
    .wn_es_traffic (wn_es_traffic),
    .starved       (starved),
    .pending_count (pending_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic applyStimulus(input logic rst_n, input logic [3:0] det, input logic [11:0] lights);
    RST         = rst_n;
    {wn_es_det, sw_ne_det, ew_det, ns_det} = det;
    {wn_es_light, sw_ne_light, ew_light, ns_light} = lights;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] exp_t,
                             input logic [3:0] exp_s, input logic [2:0] exp_p);
    logic [3:0] act_t;
    act_t = {wn_es_traffic, sw_ne_traffic, ew_traffic, ns_traffic};
    checks++;
    if (act_t !== exp_t || starved !== exp_s || pending_count !== exp_p) begin
      failures++;
      $display("[TB] FAIL %s: traffic=%b starved=%b pend=%0d, expected traffic=%b starved=%b pend=%0d",
               name, act_t, starved, pending_count, exp_t, exp_s, exp_p);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    vecs[0]  = '{1'b0, 4'b1111, {R, R, R, R},      3, 4'b0000, 4'b0000, 3'd0, "reset_hold"};
    vecs[1]  = '{1'b1, 4'b0001, {R, R, R, R},      1, 4'b0000, 4'b0000, 3'd0, "first_edge_after_release"};
    vecs[2]  = '{1'b1, 4'b0001, {R, R, R, R},      4, 4'b0000, 4'b0000, 3'd0, "ns_before_e6"};
    vecs[3]  = '{1'b1, 4'b0001, {R, R, R, R},      1, 4'b0001, 4'b0000, 3'd1, "ns_latched_e6"};
    vecs[4]  = '{1'b1, 4'b0001, {R, R, R, G},      1, 4'b0000, 4'b0000, 3'd0, "ns_served"};
    vecs[5]  = '{1'b1, 4'b0001, {R, R, R, G},      6, 4'b0000, 4'b0000, 3'd0, "ns_no_rerequest_green"};
    vecs[6]  = '{1'b1, 4'b0001, {R, R, R, R},      3, 4'b0000, 4'b0000, 3'd0, "ns_relatch_pending"};
    vecs[7]  = '{1'b1, 4'b0001, {R, R, R, R},      1, 4'b0001, 4'b0000, 3'd1, "ns_relatch"};
    vecs[8]  = '{1'b1, 4'b0001, {R, R, R, G},      1, 4'b0000, 4'b0000, 3'd0, "ns_served_again"};
    vecs[9]  = '{1'b1, 4'b0000, {R, R, R, R},      3, 4'b0000, 4'b0000, 3'd0, "ns_idle"};
    vecs[10] = '{1'b1, 4'b0001, {R, R, R, 3'b011}, 6, 4'b0001, 4'b0000, 3'd1, "non_onehot_not_green"};
    vecs[11] = '{1'b1, 4'b0001, {R, R, R, 3'b000}, 1, 4'b0001, 4'b0000, 3'd1, "all_zero_not_green"};
    vecs[12] = '{1'b1, 4'b0001, {R, R, R, G},      1, 4'b0000, 4'b0000, 3'd0, "green_after_dark"};
    vecs[13] = '{1'b1, 4'b0000, {R, R, R, R},      3, 4'b0000, 4'b0000, 3'd0, "ns_idle_again"};

    applyStimulus(1'b0, 4'b1111, {R, R, R, R});
    #1;
    checkOutput("reset_async", 4'b0000, 4'b0000, 3'd0);

    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].rst_n, vecs[i].det, vecs[i].lights);
      step(vecs[i].ncyc);
      checkOutput(vecs[i].name, vecs[i].traffic, vecs[i].starv, vecs[i].pend);
    end

    // Glitch on ew: 3 high, 1 low, then a full run; a later 1-cycle low keeps the request.
    ew_det = 1'b1; step(3);
    ew_det = 1'b0; step(1);
    ew_det = 1'b1; step(5);
    checkOutput("ew_glitch_restart", 4'b0000, 4'b0000, 3'd0);
    step(1);
    checkOutput("ew_latched_after_rerun", 4'b0010, 4'b0000, 3'd1);
    ew_det = 1'b0; step(1);
    ew_det = 1'b1; step(5);
    checkOutput("ew_glitch_keeps_req", 4'b0010, 4'b0000, 3'd1);
    ew_det = 1'b0; ew_light = G; step(1);
    checkOutput("ew_served", 4'b0000, 4'b0000, 3'd0);
    ew_light = R; step(3);

    // sw_ne count completes on the very edge its light turns green.
    sw_ne_det = 1'b1; step(5);
    checkOutput("swne_before_set", 4'b0000, 4'b0000, 3'd0);
    sw_ne_light = G; step(1);
    checkOutput("swne_clear_wins", 4'b0000, 4'b0000, 3'd0);
    sw_ne_light = R; step(3);
    checkOutput("swne_relatch_pending", 4'b0000, 4'b0000, 3'd0);
    step(1);
    checkOutput("swne_relatch", 4'b0100, 4'b0000, 3'd1);
    sw_ne_light = G; step(1);
    sw_ne_det = 1'b0; sw_ne_light = R; step(3);
    checkOutput("swne_idle", 4'b0000, 4'b0000, 3'd0);

    // wn_es never served: starved exactly 8 edges after the request sets.
    wn_es_det = 1'b1; step(6);
    checkOutput("wnes_latched", 4'b1000, 4'b0000, 3'd1);
    step(7);
    checkOutput("wnes_age7", 4'b1000, 4'b0000, 3'd1);
    step(1);
    checkOutput("wnes_starved", 4'b1000, 4'b1000, 3'd1);
    step(5);
    checkOutput("wnes_starved_holds", 4'b1000, 4'b1000, 3'd1);
    wn_es_light = G; step(1);
    checkOutput("wnes_served_clears", 4'b0000, 4'b0000, 3'd0);
    wn_es_det = 1'b0; wn_es_light = R; step(3);

    // All four together, then reset in the middle of aging.
    applyStimulus(1'b1, 4'b1111, {R, R, R, R});
    step(5);
    checkOutput("all_before_set", 4'b0000, 4'b0000, 3'd0);
    step(1);
    checkOutput("all_set_same_edge", 4'b1111, 4'b0000, 3'd4);
    step(3);
    checkOutput("all_aging", 4'b1111, 4'b0000, 3'd4);
    RST = 1'b0; #1;
    checkOutput("reset_mid_age", 4'b0000, 4'b0000, 3'd0);
    RST = 1'b1; step(1);
    checkOutput("post_reset_edge1", 4'b0000, 4'b0000, 3'd0);
    step(4);
    checkOutput("post_reset_e5", 4'b0000, 4'b0000, 3'd0);
    step(1);
    checkOutput("post_reset_relatch", 4'b1111, 4'b0000, 3'd4);
    step(8);
    checkOutput("all_starved", 4'b1111, 4'b1111, 3'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
